// File: rtl/regfile_wb_arbiter.sv
// Two-port register-file writeback arbiter with anti-starvation for the
// long-latency port and a pending-write scoreboard for issue hazard checks.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  input  logic [4:0]  p0_addr,
  input  logic [31:0] p0_data,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [4:0]  p1_addr,
  input  logic [31:0] p1_data,
  output logic        p1_ready,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic        mark_valid,
  input  logic [4:0]  mark_addr,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        hazard
);

  logic [1:0]  starve;
  logic [31:0] busy;
  logic [31:0] busy_next;
  logic        force_p1;
  logic        p0_grant;
  logic        p1_grant;
  logic        xfer;
  logic [4:0]  xfer_addr;
  logic [31:0] xfer_data;

  // p1 overrides p0 once it has been passed over three cycles in a row.
  always_comb begin
    force_p1  = p1_valid && (starve == 2'd3);
    p0_grant  = !rst && p0_valid && !force_p1;
    p1_grant  = !rst && p1_valid && (force_p1 || !p0_valid);
    xfer      = p0_grant || p1_grant;
    xfer_addr = p1_grant ? p1_addr : p0_addr;
    xfer_data = p1_grant ? p1_data : p0_data;
  end

  assign p0_ready = p0_grant;
  assign p1_ready = p1_grant;
  assign hazard   = busy[chk_addr1] | busy[chk_addr2];

  // Clear on writeback first, then mark, so a same-cycle mark wins.
  always_comb begin
    busy_next = busy;
    if (xfer) begin
      busy_next[xfer_addr] = 1'b0;
    end
    if (mark_valid) begin
      busy_next[mark_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve <= '0;
      busy   <= '0;
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else begin
      busy <= busy_next;
      if (!p1_valid || p1_grant) begin
        starve <= '0;
      end else if (starve != 2'd3) begin
        starve <= starve + 2'd1;
      end
      we <= xfer && (xfer_addr != 5'd0);
      if (xfer && (xfer_addr != 5'd0)) begin
        waddr <= xfer_addr;
        wdata <= xfer_data;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and register address width at 5 bits.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 p0_valid  input  1  port 0 (ALU writeback) write request.
REQ-005 p0_addr  input  5  port 0 destination register.
REQ-006 p0_data  input  32  port 0 write data.
REQ-007 p0_ready  output  1  port 0 grant, combinational.
REQ-008 p1_valid  input  1  port 1 (long-latency unit writeback) write request.
REQ-009 p1_addr  input  5  port 1 destination register.
REQ-010 p1_data  input  32  port 1 write data.
REQ-011 p1_ready  output  1  port 1 grant, combinational.
REQ-012 we  output  1  registered register-file write enable.
REQ-013 waddr  output  5  registered register-file write address.
REQ-014 wdata  output  32  registered register-file write data.
REQ-015 mark_valid  input  1  issue stage reserves a destination register.
REQ-016 mark_addr  input  5  register being reserved.
REQ-017 chk_addr1  input  5  first source register checked for hazard.
REQ-018 chk_addr2  input  5  second source register checked for hazard.
REQ-019 hazard  output  1  combinational: a checked source has a pending write.

Function
REQ-020 A transfer on port n SHALL occur in a cycle where pn_valid and pn_ready are both 1; at most one port SHALL transfer per cycle.
REQ-021 Default arbitration SHALL be fixed priority: p0 granted whenever p0_valid=1, else p1 granted when p1_valid=1.
REQ-022 A 2-bit starve counter SHALL increment each cycle p1_valid=1 and p1 is not granted, saturating at 3.
REQ-023 When starve counter equals 3 and p1_valid=1, p1 SHALL be granted and p0_ready SHALL be 0 that cycle.
REQ-024 Starve counter SHALL clear on any p1 transfer or any cycle with p1_valid=0.
REQ-025 pn_ready SHALL be 0 when pn_valid=0 (grant only to requesting port).
REQ-026 Latency: a transfer in cycle N SHALL produce we=1, waddr, wdata of the winner in cycle N+1; with no transfer, we=0 in N+1 and waddr/wdata hold.
REQ-027 A transfer with address 0 SHALL be accepted (ready=1) but SHALL produce we=0 in N+1.
REQ-028 Scoreboard: 32-bit busy vector; mark_valid=1 SHALL set busy[mark_addr] from next cycle; mark to address 0 SHALL be ignored; busy[0] SHALL always be 0.
REQ-029 A transfer to address A SHALL clear busy[A] from next cycle.
REQ-030 Same-cycle mark and transfer to the same address SHALL leave busy set (mark wins).
REQ-031 hazard SHALL equal busy[chk_addr1] OR busy[chk_addr2], evaluated on current-cycle state, without forwarding from the same-cycle transfer.
REQ-032 Transfers to a non-busy register SHALL be accepted and written normally; busy state SHALL remain 0.
REQ-033 Input data on a non-granted port SHALL NOT affect any output or state.

Reset
REQ-034 With rst=1 at a rising edge: we=0, waddr=0, wdata=0, busy vector=0, starve counter=0.
REQ-035 While rst=1, p0_ready and p1_ready SHALL be 0 and no transfer, mark or clear SHALL take effect.
REQ-036 Reset asserted mid-stream SHALL discard the in-flight registered write (we=0 in the cycle after the reset edge).

Verification
REQ-037 p0 only: p0_valid=1, addr=5, data=0xDEADBEEF in cycle N -> p0_ready=1 in N; we=1, waddr=5, wdata=0xDEADBEEF in N+1; we=0 in N+2.
REQ-038 Contention: p0 and p1 valid continuously -> p0 granted cycles 0-2, p1 granted cycle 3 (starve=3), p0 granted cycle 4, counter restarts.
REQ-039 Address 0: p1 transfer addr=0, data=0x1234 -> p1_ready=1, we stays 0 next cycle.
REQ-040 Scoreboard: mark addr 7 in cycle N; chk_addr1=7 -> hazard=0 in N, 1 in N+1; p1 transfer to 7 in N+3 -> hazard=0 in N+4.
REQ-041 Collision: mark addr 9 and p0 transfer to 9 same cycle -> busy[9]=1 next cycle, hazard=1 with chk_addr2=9.
REQ-042 Reset mid-operation: busy[3]=1, transfer in cycle N, rst=1 in N -> we=0, busy=0, hazard=0 in N+1.
